// File: rtl/xge_wb_host_pkg.sv
// Shared types and MAC register map for the 10GE MAC Wishbone host.
package xge_wb_host_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS_CMD = 2'd1,
        BUS_IRQ = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [7:0] REG_CFG         = 8'h00;
    localparam logic [7:0] REG_INT_PENDING = 8'h08;
    localparam logic [7:0] REG_INT_STATUS  = 8'h0C;
    localparam logic [7:0] REG_INT_MASK    = 8'h10;

endpackage

// File: rtl/xge_wb_host.sv
// Wishbone classic single-cycle master for the 10GE MAC register port, with
// automatic interrupt-pending service and a post-service holdoff window.
module xge_wb_host
    import xge_wb_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [7:0]  ISR_ADDR       = REG_INT_PENDING,
    parameter int unsigned HOLDOFF_CYCLES = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        irq_valid,
    output logic [31:0] irq_vector,
    output logic        irq_err,
    output logic [7:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_int_i
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_CYCLES);

    state_t        state_q, state_d;
    logic [7:0]    adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          we_q, we_d;
    logic          cyc_q, cyc_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          irq_valid_q, irq_valid_d;
    logic [31:0]   irq_vector_q, irq_vector_d;
    logic          irq_err_q, irq_err_d;

    logic          irq_req;
    logic [TW-1:0] tmo_next;
    logic          bus_end;
    logic [31:0]   bus_rdata;

    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        we_d         = we_q;
        cyc_d        = cyc_q;
        tmo_d        = tmo_q;
        hold_d       = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        irq_valid_d  = 1'b0;
        irq_vector_d = irq_vector_q;
        irq_err_d    = irq_err_q;

        irq_req   = wb_int_i & (hold_q == '0);
        cmd_ready = (state_q == IDLE) & ~wb_rst_i & ~irq_req;
        tmo_next  = tmo_q + TW'(1);
        // Ack wins over a timeout landing in the same cycle.
        bus_end   = wb_ack_i | (tmo_next == TMO_LIMIT);
        bus_rdata = wb_ack_i ? wb_dat_i : '0;

        unique case (state_q)
            IDLE: begin
                if (irq_req) begin
                    state_d = BUS_IRQ;
                    adr_d   = ISR_ADDR;
                    we_d    = 1'b0;
                    cyc_d   = 1'b1;
                    tmo_d   = '0;
                end else if (cmd_valid) begin
                    state_d = BUS_CMD;
                    adr_d   = cmd_addr;
                    dat_d   = cmd_wdata;
                    we_d    = cmd_we;
                    cyc_d   = 1'b1;
                    tmo_d   = '0;
                end
            end
            BUS_CMD, BUS_IRQ: begin
                tmo_d = tmo_next;
                if (bus_end) begin
                    state_d = DONE;
                    cyc_d   = 1'b0;
                    if (state_q == BUS_CMD) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = we_q ? '0 : bus_rdata;
                        rsp_err_d   = ~wb_ack_i;
                    end else begin
                        irq_valid_d  = 1'b1;
                        irq_vector_d = bus_rdata;
                        irq_err_d    = ~wb_ack_i;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                // irq_valid_q is high only in the DONE cycle following an ISR read.
                if (irq_valid_q) begin
                    hold_d = HOLD_INIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            adr_q        <= '0;
            dat_q        <= '0;
            we_q         <= 1'b0;
            cyc_q        <= 1'b0;
            tmo_q        <= '0;
            hold_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            irq_valid_q  <= 1'b0;
            irq_vector_q <= '0;
            irq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            we_q         <= we_d;
            cyc_q        <= cyc_d;
            tmo_q        <= tmo_d;
            hold_q       <= hold_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            irq_valid_q  <= irq_valid_d;
            irq_vector_q <= irq_vector_d;
            irq_err_q    <= irq_err_d;
        end
    end

    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_we_o    = we_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign irq_valid  = irq_valid_q;
    assign irq_vector = irq_vector_q;
    assign irq_err    = irq_err_q;

endmodule

// File: tb/tb_xge_wb_host.sv
// Scoreboard bench for xge_wb_host: a programmable Wishbone slave, a bus/response
// monitor, and one task per scenario comparing monitored transactions to expectations.
module tb_xge_wb_host;
    import xge_wb_host_pkg::*;

    typedef struct packed {
        logic [7:0]  adr;
        logic        we;
        logic [31:0] wdat;
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  len;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_we = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_int_i = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_err, irq_valid, irq_err;
    logic [31:0] rsp_rdata, irq_vector, wb_dat_o;
    logic [7:0]  wb_adr_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;

    always #5 clk = ~clk;

    xge_wb_host #(
        .TIMEOUT_CYCLES(16),
        .ISR_ADDR(REG_INT_PENDING),
        .HOLDOFF_CYCLES(4)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .irq_valid(irq_valid), .irq_vector(irq_vector), .irq_err(irq_err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_int_i(wb_int_i)
    );

    int   vectors = 0;
    int   miscompares = 0;
    int   cycle_count = 0;
    int   last_rsp_cyc = 0;
    txn_t exp_q[$], got_q[$], exp_irq_q[$], got_irq_q[$];

    int          slave_wait = 0;
    logic [31:0] slave_data = '0;
    bit          slave_mute = 1'b0;
    bit          late_ack = 1'b0;
    int          bus_cnt = 0;

    always @(posedge clk) cycle_count++;

    // Slave: acks after slave_wait wait states; late_ack drives ack while the bus is idle.
    always @(posedge clk) begin
        #1;
        if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1 && !slave_mute) begin
            wb_ack_i = (bus_cnt == slave_wait);
            wb_dat_i = wb_ack_i ? slave_data : 32'h0;
            bus_cnt++;
        end else begin
            wb_ack_i = late_ack && (wb_cyc_o !== 1'b1);
            wb_dat_i = late_ack ? 32'hDEAD_BEEF : 32'h0;
            if (wb_cyc_o !== 1'b1) bus_cnt = 0;
        end
    end

    txn_t cur = '0;
    logic cyc_prev = 1'b0;
    always @(negedge clk) begin
        txn_t t;
        if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1) begin
            if (!cyc_prev) begin
                cur.adr  = wb_adr_o;
                cur.we   = wb_we_o;
                cur.wdat = wb_dat_o;
                cur.len  = 8'd1;
            end else begin
                cur.len = cur.len + 8'd1;
            end
        end
        cyc_prev = (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1);
        if (rsp_valid === 1'b1) begin
            cur.rdata = rsp_rdata;
            cur.err   = rsp_err;
            got_q.push_back(cur);
            last_rsp_cyc = cycle_count;
        end
        if (irq_valid === 1'b1) begin
            t       = cur;
            t.wdat  = '0;
            t.rdata = irq_vector;
            t.err   = irq_err;
            got_irq_q.push_back(t);
        end
    end

    // Drives one command and holds it until the handshake; acc is the handshake cycle.
    task automatic issue(input logic we, input logic [7:0] a, input logic [31:0] d,
                         output int acc);
        cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1; acc = -1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (cmd_ready === 1'b1) begin
                acc = cycle_count;
                break;
            end
            @(negedge clk);
        end
        if (acc >= 0) begin
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 200 && got_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid, rsp_err, irq_valid, irq_err, cmd_ready} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b expected 00000000",
                     {wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid, rsp_err, irq_valid, irq_err, cmd_ready});
        end
        vectors++;
        if ({wb_adr_o, wb_dat_o, rsp_rdata, irq_vector} !== 104'h0) begin
            miscompares++;
            $display("FAIL reset_data got %h expected 0", {wb_adr_o, wb_dat_o, rsp_rdata, irq_vector});
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_write_zero_wait;
        int acc; txn_t e, g;
        slave_wait = 0;
        exp_q.push_back(txn_t'{adr: 8'h00, we: 1'b1, wdat: 32'h1, rdata: 32'h0, err: 1'b0, len: 8'd1});
        @(negedge clk);
        issue(1'b1, REG_CFG, 32'h0000_0001, acc);
        wait_rsp(1);
        vectors++;
        if (acc < 0 || got_q.size() == 0) begin
            miscompares++;
            $display("FAIL write_rsp got none (acc %0d) expected %h", acc, exp_q[0]);
            exp_q.delete();
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) begin
                miscompares++;
                $display("FAIL write_rsp got %h expected %h", g, e);
            end
            vectors++;
            if (last_rsp_cyc - acc !== 2) begin
                miscompares++;
                $display("FAIL write_latency got %0d expected 2", last_rsp_cyc - acc);
            end
        end
    endtask

    task automatic test_read_wait;
        int acc; txn_t e, g;
        slave_wait = 3; slave_data = 32'h0000_00FF;
        exp_q.push_back(txn_t'{adr: 8'h10, we: 1'b0, wdat: 32'h0, rdata: 32'hFF, err: 1'b0, len: 8'd4});
        @(negedge clk);
        issue(1'b0, REG_INT_MASK, 32'h0, acc);
        wait_rsp(1);
        vectors++;
        if (got_q.size() == 0) begin
            miscompares++;
            $display("FAIL read_wait_rsp got none expected %h", exp_q[0]);
            exp_q.delete();
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) begin
                miscompares++;
                $display("FAIL read_wait_rsp got %h expected %h", g, e);
            end
        end
        slave_wait = 0;
    endtask

    task automatic test_timeout;
        int acc; txn_t e, g;
        slave_mute = 1'b1;
        exp_q.push_back(txn_t'{adr: 8'h0C, we: 1'b0, wdat: 32'h0, rdata: 32'h0, err: 1'b1, len: 8'd16});
        @(negedge clk);
        issue(1'b0, REG_INT_STATUS, 32'h0, acc);
        wait_rsp(1);
        slave_mute = 1'b0;
        exp_q.push_back(txn_t'{adr: 8'h10, we: 1'b1, wdat: 32'hAA, rdata: 32'h0, err: 1'b0, len: 8'd1});
        @(negedge clk);
        issue(1'b1, REG_INT_MASK, 32'h0000_00AA, acc);
        wait_rsp(2);
        while (exp_q.size() > 0) begin
            vectors++;
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                miscompares++;
                $display("FAIL timeout_rsp got none expected %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL timeout_rsp got %h expected %h", g, e);
                end
            end
        end
    endtask

    task automatic test_irq_priority;
        int k; bit seen; txn_t e, g;
        slave_wait = 0; slave_data = 32'h0000_0004;
        exp_irq_q.push_back(txn_t'{adr: 8'h08, we: 1'b0, wdat: 32'h0, rdata: 32'h4, err: 1'b0, len: 8'd1});
        exp_q.push_back(txn_t'{adr: 8'h10, we: 1'b0, wdat: 32'h0, rdata: 32'hCAFE_0001, err: 1'b0, len: 8'd1});
        @(negedge clk);
        wb_int_i = 1'b1;
        cmd_we = 1'b0; cmd_addr = 8'h10; cmd_wdata = 32'h0; cmd_valid = 1'b1;
        #1;
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_blocks_ready got %b expected 0", cmd_ready);
        end
        seen = 1'b0; k = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!seen && irq_valid === 1'b1) begin
                seen = 1'b1;
                slave_data = 32'hCAFE_0001;
            end else if (seen) begin
                k++;
                if (k == 3) wb_int_i = 1'b0;
            end
            if (wb_cyc_o === 1'b1 && wb_adr_o === 8'h10) cmd_valid = 1'b0;
            if (seen && k >= 12) break;
        end
        cmd_valid = 1'b0; wb_int_i = 1'b0;
        vectors++;
        if (got_irq_q.size() != 1) begin
            miscompares++;
            $display("FAIL irq_count got %0d expected 1", got_irq_q.size());
        end
        if (got_irq_q.size() > 0) begin
            vectors++;
            e = exp_irq_q.pop_front(); g = got_irq_q.pop_front();
            if (g !== e) begin
                miscompares++;
                $display("FAIL irq_service got %h expected %h", g, e);
            end
        end
        exp_irq_q.delete(); got_irq_q.delete();
        vectors++;
        if (got_q.size() == 0) begin
            miscompares++;
            $display("FAIL queued_cmd got none expected %h", exp_q[0]);
            exp_q.delete();
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) begin
                miscompares++;
                $display("FAIL queued_cmd got %h expected %h", g, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        int acc;
        slave_mute = 1'b1;
        @(negedge clk);
        issue(1'b0, REG_INT_STATUS, 32'h0, acc);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({wb_cyc_o, wb_stb_o, rsp_valid, irq_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid_bus got %b expected 0000", {wb_cyc_o, wb_stb_o, rsp_valid, irq_valid});
        end
        late_ack = 1'b1; slave_mute = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({wb_cyc_o, wb_stb_o, rsp_valid, irq_valid} !== 4'b0000) begin
                miscompares++;
                $display("FAIL late_ack_ignored got %b expected 0000", {wb_cyc_o, wb_stb_o, rsp_valid, irq_valid});
            end
        end
        late_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (got_q.size() != 0 || got_irq_q.size() != 0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_quiet got rsp %0d irq %0d ready %b expected 0 0 1",
                     got_q.size(), got_irq_q.size(), cmd_ready);
        end
        got_q.delete(); got_irq_q.delete();
    endtask

    task automatic test_back_to_back;
        int acc[3]; txn_t e, g;
        logic        we_t[3];
        logic [7:0]  ad_t[3];
        logic [31:0] wd_t[3];
        we_t = '{1'b1, 1'b0, 1'b1};
        ad_t = '{8'h0C, 8'h10, 8'h00};
        wd_t = '{32'h0000_00A5, 32'h0000_0000, 32'h8000_0001};
        slave_wait = 0; slave_data = 32'h1234_5678;
        for (int i = 0; i < 3; i++)
            exp_q.push_back(txn_t'{adr: ad_t[i], we: we_t[i], wdat: wd_t[i],
                                   rdata: we_t[i] ? 32'h0 : 32'h1234_5678, err: 1'b0, len: 8'd1});
        @(negedge clk);
        for (int i = 0; i < 3; i++) issue(we_t[i], ad_t[i], wd_t[i], acc[i]);
        wait_rsp(3);
        for (int i = 1; i < 3; i++) begin
            vectors++;
            if (acc[i] - acc[i-1] !== 3) begin
                miscompares++;
                $display("FAIL b2b_spacing%0d got %0d expected 3", i, acc[i] - acc[i-1]);
            end
        end
        while (exp_q.size() > 0) begin
            vectors++;
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                miscompares++;
                $display("FAIL b2b_rsp got none expected %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL b2b_rsp got %h expected %h", g, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_timeout();
        test_irq_priority();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d expected completion", cycle_count);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/xge_wb_host.md
# xge_wb_host

Single-clock Wishbone master (host-side initiator) for the 10GE MAC's register interface. Turns one-at-a-time local read/write commands into classic Wishbone single cycles. Automatically services the MAC interrupt line by reading the interrupt-pending register. Sits between the board/CPU-side control logic and the MAC's `wb_*` slave port, in the `wb_clk_i` domain.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16 — max cycles `wb_cyc_o` stays high without `wb_ack_i` before abort (≥2)
- `ISR_ADDR`, 8'h08 — address read on interrupt service (MAC interrupt-pending, clear-on-read)
- `HOLDOFF_CYCLES`, 4 — cycles after an interrupt service during which `wb_int_i` is ignored (≥1)

Ports:
- `wb_clk_i` in 1 — clock. One clock; reset is synchronous and active-high.
- `wb_rst_i` in 1 — synchronous active-high reset
- `cmd_valid` in 1 — command request
- `cmd_ready` out 1 — command accepted when `cmd_valid & cmd_ready`
- `cmd_we` in 1 — 1 = write, 0 = read
- `cmd_addr` in 8 — register address
- `cmd_wdata` in 32 — write data
- `rsp_valid` out 1 — one-cycle pulse, command complete
- `rsp_rdata` out 32 — read data (0 for writes or on error)
- `rsp_err` out 1 — timeout abort, qualified by `rsp_valid`
- `irq_valid` out 1 — one-cycle pulse, interrupt service complete
- `irq_vector` out 32 — pending-register value read
- `irq_err` out 1 — ISR read timed out, qualified by `irq_valid`
- `wb_adr_o` out 8, `wb_dat_o` out 32, `wb_we_o` out 1, `wb_cyc_o` out 1, `wb_stb_o` out 1 — Wishbone master outputs
- `wb_dat_i` in 32, `wb_ack_i` in 1, `wb_int_i` in 1 — Wishbone slave returns and MAC interrupt

## Operation
- States:
  - IDLE
  - BUS_CMD
  - BUS_IRQ
  - DONE
- Transitions out of IDLE:
  - IDLE → BUS_IRQ when `wb_int_i` = 1 and holdoff counter = 0.
  - Otherwise IDLE → BUS_CMD on `cmd_valid & cmd_ready`.
- `cmd_ready` = (state == IDLE) & ~(`wb_int_i` & holdoff == 0). Interrupt wins a simultaneous request; the command waits and is not dropped.
- On entry to a BUS state, register:
  - BUS_CMD: `wb_adr_o` ← `cmd_addr`, `wb_dat_o` ← `cmd_wdata`, `wb_we_o` ← `cmd_we`.
  - BUS_IRQ: `wb_adr_o` ← `ISR_ADDR`, `wb_we_o` ← 0.
  - In both: `wb_cyc_o` and `wb_stb_o` ← 1.
- Address and data are stable for the whole cycle.
- In a BUS state:
  - The timeout counter increments each cycle.
  - On `wb_ack_i`: capture `wb_dat_i` (reads), deassert `cyc`/`stb`, go to DONE.
  - If the counter reaches `TIMEOUT_CYCLES` without ack: deassert, set error, go to DONE.
  - Ack and timeout in the same cycle: ack wins, no error.
- DONE (one cycle):
  - After BUS_CMD: pulse `rsp_valid` with data and error.
  - After BUS_IRQ: pulse `irq_valid`, load holdoff with `HOLDOFF_CYCLES`.
  - Then return to IDLE.
- Holdoff counter decrements to 0 in any state. It suppresses re-servicing while the MAC deasserts its interrupt.
- Reset state:
  - IDLE.
  - All outputs 0, `cmd_ready` 0 during reset.
  - Counters 0.
- Reset mid-cycle: `cyc`/`stb` low on the next edge, no `rsp_valid`/`irq_valid`.
- `wb_ack_i` while not in a BUS state is ignored.

## Timing
- Command accepted at edge N → `wb_cyc_o`/`wb_stb_o` high from N+1.
- Ack sampled high at edge M → `cyc`/`stb` low and `rsp_valid` high at M+1 → `cmd_ready` high again at M+2.
- Zero-wait slave (ack in first bus cycle): accept-to-response = 2 cycles; back-to-back commands every 3 cycles.
- Timeout: `cyc` high exactly `TIMEOUT_CYCLES` cycles, then `rsp_err` pulse on the next cycle.
- Outputs are all registered; `cmd_ready` is the only combinational output.

## Structure
- Package `xge_wb_host_pkg`:
  - state enum (IDLE, BUS_CMD, BUS_IRQ, DONE)
  - MAC register address constants: CFG 8'h00, INT_PENDING 8'h08, INT_STATUS 8'h0C, INT_MASK 8'h10
- Timeout counter width `$clog2(TIMEOUT_CYCLES+1)`; holdoff counter width `$clog2(HOLDOFF_CYCLES+1)`.
- Single module, no sub-module required.

## Test plan
- Write 8'h00 ← 32'h0000_0001, slave acks first cycle → `wb_we_o`=1, adr 8'h00, dat 32'h1 for one cycle; `rsp_valid` two cycles after accept, `rsp_err`=0, `rsp_rdata`=0.
- Read 8'h10, slave acks after 3 wait cycles with 32'h0000_00FF → `cyc` high 4 cycles; `rsp_rdata`=32'hFF.
- Read to a never-acking slave, `TIMEOUT_CYCLES`=16 → `cyc` high 16 cycles; `rsp_err`=1, `rsp_rdata`=0; next command accepted normally.
- `wb_int_i` rises in the same cycle as `cmd_valid`:
  - `cmd_ready` low; read of 8'h08 issued, returns 32'h0000_0004 → `irq_valid`, `irq_vector`=32'h4.
  - Then the queued command is accepted.
  - `wb_int_i` held high for 3 more cycles causes no second service.
- `wb_rst_i` asserted mid-transaction → `cyc`/`stb` low next cycle, no response pulse; a late `wb_ack_i` is ignored.
